scr1_mmio_timer: RTL

SCR1_MMIO_TIMER -- requirements
Module: scr1_mmio_timer

---
 rtl/scr1_mmio_timer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/scr1_mmio_timer.sv
// rtl/scr1_mmio_timer.sv - memory-mapped machine timer with prescaler, RTC source and compare interrupt
module scr1_mmio_timer #(
    parameter int DIV_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rtc_clk,
    input  logic        dmem_req,
    input  logic        dmem_cmd,
    input  logic [1:0]  dmem_width,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_req_ack,
    output logic [31:0] dmem_rdata,
    output logic [1:0]  dmem_resp,
    output logic        timer_irq,
    output logic [63:0] timer_val
);

    localparam logic [1:0] RESP_IDLE = 2'd0;
    localparam logic [1:0] RESP_RDY  = 2'd1;
    localparam logic [1:0] RESP_ER   = 2'd2;

    localparam logic [4:0] OFS_CTRL     = 5'h00;
    localparam logic [4:0] OFS_DIV      = 5'h04;
    localparam logic [4:0] OFS_MTIMELO  = 5'h08;
    localparam logic [4:0] OFS_MTIMEHI  = 5'h0C;
    localparam logic [4:0] OFS_MTCMPLO  = 5'h10;
    localparam logic [4:0] OFS_MTCMPHI  = 5'h14;

    logic [1:0]       ctrl_q, ctrl_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic             irq_q;
    logic [1:0]       resp_q, resp_d;
    logic             rd_q, rd_d;
    logic [2:0]       raddr_q, raddr_d;
    logic             rtc_s1_q, rtc_s2_q, rtc_s3_q;

    logic [4:0]  offset;
    logic        acc_err;
    logic        wr_en;
    logic        wr_ctrl, wr_div, wr_mlo, wr_mhi, wr_clo, wr_chi;
    logic        rtc_pulse;
    logic        src_pulse;
    logic        tick;
    logic [31:0] div_ext;
    logic [31:0] rd_mux;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^dmem_addr[31:5];

    assign offset  = dmem_addr[4:0];
    assign acc_err = (dmem_width != 2'd2) || (dmem_addr[1:0] != 2'b00) || (offset > OFS_MTCMPHI);
    assign wr_en   = dmem_req && dmem_cmd && !acc_err;

    assign wr_ctrl = wr_en && (offset == OFS_CTRL);
    assign wr_div  = wr_en && (offset == OFS_DIV);
    assign wr_mlo  = wr_en && (offset == OFS_MTIMELO);
    assign wr_mhi  = wr_en && (offset == OFS_MTIMEHI);
    assign wr_clo  = wr_en && (offset == OFS_MTCMPLO);
    assign wr_chi  = wr_en && (offset == OFS_MTCMPHI);

    assign dmem_req_ack = dmem_req;

    // Third flop only remembers the previous synchronized level for edge detection.
    assign rtc_pulse = rtc_s2_q && !rtc_s3_q;
    assign src_pulse = ctrl_q[1] ? rtc_pulse : 1'b1;
    assign tick      = ctrl_q[0] && src_pulse && (presc_q == div_q);

    always_comb begin
        ctrl_d     = ctrl_q;
        div_d      = div_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_ctrl) ctrl_d = dmem_wdata[1:0];
        if (wr_div)  div_d  = dmem_wdata[DIV_W-1:0];
        if (wr_clo)  mtimecmp_d = {mtimecmp_q[63:32], dmem_wdata};
        if (wr_chi)  mtimecmp_d = {dmem_wdata, mtimecmp_q[31:0]};
    end

    always_comb begin
        presc_d = presc_q;
        if (ctrl_q[0] && src_pulse) begin
            presc_d = tick ? '0 : presc_q + DIV_W'(1);
        end
        if (wr_ctrl || wr_div) begin
            presc_d = '0;
        end
    end

    // A CPU write to either mtime half wins over a coincident tick.
    always_comb begin
        mtime_d = mtime_q;
        if (tick)   mtime_d = mtime_q + 64'd1;
        if (wr_mlo) mtime_d = {mtime_q[63:32], dmem_wdata};
        if (wr_mhi) mtime_d = {dmem_wdata, mtime_q[31:0]};
    end

    always_comb begin
        resp_d  = RESP_IDLE;
        rd_d    = 1'b0;
        raddr_d = raddr_q;
        if (dmem_req) begin
            resp_d  = acc_err ? RESP_ER : RESP_RDY;
            rd_d    = !dmem_cmd && !acc_err;
            raddr_d = offset[4:2];
        end
    end

    always_comb begin
        div_ext = '0;
        div_ext[DIV_W-1:0] = div_q;
    end

    always_comb begin
        rd_mux = '0;
        case (raddr_q)
            3'd0:    rd_mux = {30'd0, ctrl_q};
            3'd1:    rd_mux = div_ext;
            3'd2:    rd_mux = mtime_q[31:0];
            3'd3:    rd_mux = mtime_q[63:32];
            3'd4:    rd_mux = mtimecmp_q[31:0];
            3'd5:    rd_mux = mtimecmp_q[63:32];
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rtc_s1_q <= 1'b0;
            rtc_s2_q <= 1'b0;
            rtc_s3_q <= 1'b0;
        end else begin
            rtc_s1_q <= rtc_clk;
            rtc_s2_q <= rtc_s1_q;
            rtc_s3_q <= rtc_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= 2'b01;
            div_q      <= '0;
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
            resp_q     <= RESP_IDLE;
            rd_q       <= 1'b0;
            raddr_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            div_q      <= div_d;
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= (mtime_q >= mtimecmp_q);
            resp_q     <= resp_d;
            rd_q       <= rd_d;
            raddr_q    <= raddr_d;
        end
    end

    assign dmem_resp  = resp_q;
    assign dmem_rdata = (rd_q && (resp_q == RESP_RDY)) ? rd_mux : 32'd0;
    assign timer_irq  = irq_q;
    assign timer_val  = mtime_q;

endmodule
